prueba_ram: RTL and testbench

- Single-port synchronous character-code RAM for the VGA text path.
- Each entry holds a 5-bit glyph code: 0 = space, 1..26 = A..Z, 27 = '*', 28 = '#'. The VGA character selector addresses it with (posx/8) + (posy/8)*80.
- On reset, a built-in clear sequencer zero-fills the array so the screen shows spaces until software writes codes.

---
 rtl/prueba_ram_pkg.sv | 36 +++
 rtl/prueba_ram_clear_seq.sv | 60 ++++++
 rtl/prueba_ram.sv | 90 +++++++++
 tb/tb_prueba_ram.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prueba_ram_pkg.sv
// ============================================================================
// Module : prueba_ram_pkg
// Brief  : Glyph codes, screen geometry and FSM state type for prueba_ram.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prueba_ram_pkg;

  localparam logic [4:0] GLYPH_SPACE = 5'd0;
  localparam logic [4:0] GLYPH_A = 5'd1,  GLYPH_B = 5'd2,  GLYPH_C = 5'd3,  GLYPH_D = 5'd4;
  localparam logic [4:0] GLYPH_E = 5'd5,  GLYPH_F = 5'd6,  GLYPH_G = 5'd7,  GLYPH_H = 5'd8;
  localparam logic [4:0] GLYPH_I = 5'd9,  GLYPH_J = 5'd10, GLYPH_K = 5'd11, GLYPH_L = 5'd12;
  localparam logic [4:0] GLYPH_M = 5'd13, GLYPH_N = 5'd14, GLYPH_O = 5'd15, GLYPH_P = 5'd16;
  localparam logic [4:0] GLYPH_Q = 5'd17, GLYPH_R = 5'd18, GLYPH_S = 5'd19, GLYPH_T = 5'd20;
  localparam logic [4:0] GLYPH_U = 5'd21, GLYPH_V = 5'd22, GLYPH_W = 5'd23, GLYPH_X = 5'd24;
  localparam logic [4:0] GLYPH_Y = 5'd25, GLYPH_Z = 5'd26;
  localparam logic [4:0] GLYPH_STAR = 5'd27;
  localparam logic [4:0] GLYPH_HASH = 5'd28;

  localparam int COLS    = 80;
  localparam int CELL_PX = 8;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // Cell index used by the VGA character selector for a pixel position.
  function automatic int unsigned char_index(input int unsigned posx, input int unsigned posy);
    return (posx / CELL_PX) + (posy / CELL_PX) * COLS;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prueba_ram_clear_seq.sv
// ============================================================================
// Module : prueba_ram_clear_seq
// Brief  : Post-reset sweep that zero-fills the character RAM, one word/cycle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prueba_ram_clear_seq
  import prueba_ram_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_init_busy
);

  // One extra bit so DEPTH == 2**ADDR_W terminates without wrapping.
  localparam logic [ADDR_W:0] c_last = (ADDR_W+1)'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W:0]   w_cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    o_init_busy  = 1'b0;
    case (r_state)
      CLEAR: begin
        o_init_busy = 1'b1;
        w_cnt_next  = r_cnt + 1'b1;
        if (r_cnt == c_last) begin
          w_state_next = IDLE;
        end
      end
      IDLE: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign o_clr_addr = r_cnt[ADDR_W-1:0];

endmodule

`default_nettype wire

// File: rtl/prueba_ram.sv
// ============================================================================
// Module : prueba_ram
// Brief  : Single-port character-code RAM with built-in clear on reset.
//          Define PRUEBA_RAM_OUTREG_EN for a second output register (2-cycle read).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prueba_ram
  import prueba_ram_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 5,
  parameter int DEPTH  = 1024
) (
  input  logic [ADDR_W-1:0] address,
  input  logic              clk,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q,
  input  logic              rst,
  output logic              init_busy
);

  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_in_range;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [DATA_W-1:0] r_q1;

  prueba_ram_clear_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear_seq (
    .clk         (clk),
    .rst         (rst),
    .o_clr_addr  (w_clr_addr),
    .o_init_busy (init_busy)
  );

  assign w_in_range = ({1'b0, address} < c_depth);

  // The sweep owns the write port while busy; user writes are dropped.
  assign w_mem_we    = init_busy | (wren & w_in_range);
  assign w_mem_addr  = init_busy ? w_clr_addr : address;
  assign w_mem_wdata = init_busy ? '0 : data;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q1 <= '0;
    end else if (init_busy || !w_in_range) begin
      r_q1 <= '0;
    end else if (wren) begin
      r_q1 <= data;
    end else begin
      r_q1 <= r_mem[address];
    end
  end

`ifdef PRUEBA_RAM_OUTREG_EN
  logic [DATA_W-1:0] r_q2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q2 <= '0;
    end else if (init_busy) begin
      r_q2 <= '0;
    end else begin
      r_q2 <= r_q1;
    end
  end

  assign q = r_q2;
`else
  assign q = r_q1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prueba_ram.sv
// Self-checking bench for prueba_ram: default instance plus a DEPTH=960 instance,
// reads checked through a latency-aware expected-value queue.
`default_nettype none

module tb_prueba_ram;

`ifdef PRUEBA_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic       chk;
    logic       sel;
    logic [9:0] addr;
    logic [4:0] exp;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] address0 = '0, address1 = '0;
  logic [4:0] data0 = '0, data1 = '0;
  logic       wren0 = 1'b0, wren1 = 1'b0;
  logic [4:0] q0, q1;
  logic       busy0, busy1;

  logic [4:0] mdl0 [0:1023];
  logic [4:0] mdl1 [0:1023];
  sb_t        sb_q [$];
  int         tests_run = 0;
  int         tests_failed = 0;

  always #5 clk = ~clk;

  prueba_ram u_dut (
    .address   (address0),
    .clk       (clk),
    .data      (data0),
    .wren      (wren0),
    .q         (q0),
    .rst       (rst),
    .init_busy (busy0)
  );

  prueba_ram #(.ADDR_W(10), .DATA_W(5), .DEPTH(960)) u_dut960 (
    .address   (address1),
    .clk       (clk),
    .data      (data1),
    .wren      (wren1),
    .q         (q1),
    .rst       (rst),
    .init_busy (busy1)
  );

  task automatic quiet();
    wren0 = 1'b0;
    wren1 = 1'b0;
  endtask

  task automatic clear_models();
    for (int i = 0; i < 1024; i++) begin
      mdl0[i] = 5'd0;
      mdl1[i] = 5'd0;
    end
    sb_q.delete();
  endtask

  // One clock of stimulus on one instance; expected read data queued for LAT edges later.
  task automatic drive(input bit sel, input int addr, input int dat, input bit we, input bit chk);
    int         depth;
    logic [4:0] e;
    logic [4:0] obs;
    sb_t        ent;
    sb_t        got;
    depth = sel ? 960 : 1024;
    if (addr >= depth) begin
      e = 5'd0;
    end else if (we) begin
      e = dat[4:0];
      if (sel) mdl1[addr] = e;
      else     mdl0[addr] = e;
    end else begin
      e = sel ? mdl1[addr] : mdl0[addr];
    end
    quiet();
    if (sel) begin
      address1 = addr[9:0]; data1 = dat[4:0]; wren1 = we;
    end else begin
      address0 = addr[9:0]; data0 = dat[4:0]; wren0 = we;
    end
    ent.chk = chk; ent.sel = sel; ent.addr = addr[9:0]; ent.exp = e;
    sb_q.push_back(ent);
    @(posedge clk);
    #1;
    if (sb_q.size() >= LAT) begin
      got = sb_q.pop_front();
      if (got.chk) begin
        obs = got.sel ? q1 : q0;
        tests_run++;
        if (obs !== got.exp) begin
          tests_failed++;
          $display("FAIL read dut%0d addr=%0d got=%0d expected=%0d",
                   got.sel ? 960 : 1024, got.addr, obs, got.exp);
        end
      end
    end
  endtask

  task automatic drain(input bit sel, input int addr);
    repeat (LAT) drive(sel, addr, 0, 1'b0, 1'b0);
    quiet();
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_bit(input string name, input logic obs, input logic exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0b expected=%0b", name, obs, exp);
    end
  endtask

  // Asserted between edges; q must drop without waiting for a clock.
  task automatic do_reset(input string tag);
    quiet();
    rst = 1'b1;
    #1;
    tests_run++;
    if (q0 !== 5'd0 || q1 !== 5'd0 || busy0 !== 1'b1 || busy1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_async q0=%0d q1=%0d busy0=%0b busy1=%0b expected q=0 busy=1",
               tag, q0, q1, busy0, busy1);
    end
    clear_models();
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_init(input string tag, input int exp0, input int exp1);
    int n, f0, f1;
    n = 0; f0 = -1; f1 = -1;
    while ((busy0 || busy1) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (!busy0 && f0 < 0) f0 = n;
      if (!busy1 && f1 < 0) f1 = n;
    end
    tests_run++;
    if (f0 != exp0) begin
      tests_failed++;
      $display("FAIL %s_sweep1024 cycles got=%0d expected=%0d", tag, f0, exp0);
    end
    tests_run++;
    if (f1 != exp1) begin
      tests_failed++;
      $display("FAIL %s_sweep960 cycles got=%0d expected=%0d", tag, f1, exp1);
    end
    sb_q.delete();
  endtask

  task automatic test_reset();
    clear_models();
    run_cycles(3);
    check_bit("reset_busy0", busy0, 1'b1);
    check_bit("reset_busy1", busy1, 1'b1);
    check_bit("reset_q0_zero", (q0 == 5'd0), 1'b1);
    rst = 1'b0;
    wait_init("por", 1024, 960);
    drive(0, 0, 0, 0, 1);
    drive(0, 512, 0, 0, 1);
    drive(0, 1023, 0, 0, 1);
    drive(1, 959, 0, 0, 1);
    drain(0, 0);
  endtask

  task automatic test_write_read();
    drive(0, 5, 3, 1, 1);
    drive(0, 5, 0, 0, 1);
    drive(0, 6, 0, 0, 1);
    drive(0, 1, 4, 1, 1);
    drive(0, 1, 0, 0, 1);
    drive(0, 1023, 27, 1, 1);
    drive(0, 1023, 0, 0, 1);
    drain(0, 0);
  endtask

  task automatic test_write_through();
    drive(0, 80, 28, 1, 1);
    drive(0, 80, 0, 0, 1);
    drive(0, 80, 0, 0, 1);
    drain(0, 80);
  endtask

  task automatic test_clear_ignore();
    do_reset("clr");
    run_cycles(99);
    address0 = 10'd10; data0 = 5'd7; wren0 = 1'b1;
    @(posedge clk);
    #1;
    check_bit("clear_q_held_zero", (q0 == 5'd0), 1'b1);
    check_bit("clear_busy", busy0, 1'b1);
    quiet();
    wait_init("clr", 924, 860);
    drive(0, 10, 0, 0, 1);
    drain(0, 0);
  endtask

  task automatic test_reset_restart();
    drive(0, 200, 13, 1, 1);
    drive(0, 200, 0, 0, 1);
    drain(0, 200);
    do_reset("idle");
    run_cycles(300);
    do_reset("mid");
    wait_init("mid", 1024, 960);
    drive(0, 200, 0, 0, 1);
    drain(0, 0);
  endtask

  task automatic test_out_of_range();
    drive(1, 1000, 9, 1, 1);
    drive(1, 1000, 0, 0, 1);
    drive(1, 959, 9, 1, 1);
    drive(1, 959, 0, 0, 1);
    drive(1, 960, 0, 0, 1);
    drain(1, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      drive(0, $urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 1), 1);
    end
    drain(0, 0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_write_through();
    test_clear_ignore();
    test_reset_restart();
    test_out_of_range();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
